// File: rtl/uart_pkg.sv
// Shared UART definitions: ASCII constants, feeder FSM states and a constant clog2.
// The CR_PEND state only exists when UART_TX_FEEDER_CRLF_EN is defined.
package uart_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_GAP     = 2'd2
`ifdef UART_TX_FEEDER_CRLF_EN
        , ST_CR_PEND = 2'd3
`endif
    } feeder_state_e;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v = value - 1;
        while (v > 0) begin
            res = res + 1;
            v = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO with occupancy level; head byte is visible combinationally.
module uart_fifo #(
    parameter int DEPTH = 16,
    parameter int LW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [7:0]    din_i,
    input  logic          pop_i,
    output logic [7:0]    dout_o,
    output logic [LW-1:0] level_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int PW = LW - 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers are one bit narrower than the level, so they wrap modulo DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Stream-to-Avalon feeder: buffers bytes and writes them to the UART transmit register.
// Define UART_TX_FEEDER_CRLF_EN to expand each LF into a CR, LF transfer pair.
//
// state    | meaning
// IDLE     | no write outstanding, waiting for FIFO data
// WRITE    | avalon_write high, waiting for waitrequest to drop
// GAP      | idle spacing after a completed write; the last gap cycle launches the next byte
// CR_PEND  | CR sent, trailing LF write outstanding (CRLF build only)
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int AAW     = 1,
    parameter int ADW     = 32,
    parameter int DEPTH   = 16,
    parameter int TX_ADDR = 0,
    parameter int GAP     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    output logic                    in_ready,
    output logic                    avalon_read,
    output logic                    avalon_write,
    output logic [AAW-1:0]          avalon_address,
    output logic [ADW/8-1:0]        avalon_byteenable,
    output logic [ADW-1:0]          avalon_writedata,
    input  logic                    avalon_waitrequest,
    output logic [clog2(DEPTH):0]   fifo_level,
    output logic                    busy
);

    localparam int LW  = clog2(DEPTH) + 1;
    localparam int GCW = (GAP > 1) ? clog2(GAP) : 1;
    localparam logic [GCW-1:0] GAP_LOAD = GCW'((GAP > 0) ? GAP - 1 : 0);

    feeder_state_e  state_q, state_d;
    logic           write_q, write_d;
    logic [7:0]     wdata_q, wdata_d;
    logic [GCW-1:0] gcnt_q, gcnt_d;
`ifdef UART_TX_FEEDER_CRLF_EN
    logic           lf_pend_q, lf_pend_d;
`endif

    logic           pop;
    logic           launch;
    logic           finish;
    logic           done;
    logic [7:0]     head;
    logic           fifo_full;
    logic           fifo_empty;

    uart_fifo #(.DEPTH(DEPTH), .LW(LW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .din_i   (in_data),
        .pop_i   (pop),
        .dout_o  (head),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready          = ~fifo_full;
    assign avalon_read       = 1'b0;
    assign avalon_write      = write_q;
    assign avalon_address    = AAW'(TX_ADDR);
    assign avalon_byteenable = {(ADW/8){1'b1}};
    assign avalon_writedata  = {{(ADW-8){1'b0}}, wdata_q};
    assign busy              = (state_q != ST_IDLE) || !fifo_empty;
    assign done              = write_q & ~avalon_waitrequest;

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        wdata_d = wdata_q;
        gcnt_d  = gcnt_q;
        pop     = 1'b0;
        launch  = 1'b0;
        finish  = 1'b0;
`ifdef UART_TX_FEEDER_CRLF_EN
        lf_pend_d = lf_pend_q;
`endif
        case (state_q)
            ST_IDLE: launch = 1'b1;
            ST_WRITE: begin
                if (done) begin
`ifdef UART_TX_FEEDER_CRLF_EN
                    if (lf_pend_q && GAP == 0) begin
                        wdata_d   = ASCII_LF;
                        lf_pend_d = 1'b0;
                        state_d   = ST_CR_PEND;
                    end else
`endif
                    finish = 1'b1;
                end
            end
            ST_GAP: begin
                if (gcnt_q != '0) gcnt_d = gcnt_q - GCW'(1);
`ifdef UART_TX_FEEDER_CRLF_EN
                else if (lf_pend_q) begin
                    write_d   = 1'b1;
                    wdata_d   = ASCII_LF;
                    lf_pend_d = 1'b0;
                    state_d   = ST_CR_PEND;
                end
`endif
                else launch = 1'b1;
            end
`ifdef UART_TX_FEEDER_CRLF_EN
            ST_CR_PEND: if (done) finish = 1'b1;
`endif
            default: state_d = ST_IDLE;
        endcase

        if (finish) begin
            if (GAP > 0) begin
                write_d = 1'b0;
                gcnt_d  = GAP_LOAD;
                state_d = ST_GAP;
            end else begin
                launch = 1'b1;
            end
        end

        // Launching with an empty FIFO parks the FSM in IDLE with the bus released
        if (launch) begin
            if (!fifo_empty) begin
                pop     = 1'b1;
                write_d = 1'b1;
                wdata_d = head;
                state_d = ST_WRITE;
`ifdef UART_TX_FEEDER_CRLF_EN
                if (head == ASCII_LF) begin
                    wdata_d   = ASCII_CR;
                    lf_pend_d = 1'b1;
                end
`endif
            end else begin
                write_d = 1'b0;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            wdata_q <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            gcnt_q  <= gcnt_d;
        end
    end

`ifdef UART_TX_FEEDER_CRLF_EN
    always_ff @(posedge clk) begin
        if (rst) lf_pend_q <= 1'b0;
        else     lf_pend_q <= lf_pend_d;
    end
`endif

endmodule
